// File: rtl/keypad_digit_entry_if.sv
// Keypad entry bus: key pulses in (keypad/key_ent/key_clr),
// live buffer, count, committed value, valid and err out.
interface keypad_digit_entry_if #(
  parameter int NUM_DIGITS = 4
);
  logic [9:0]              keypad;
  logic                    key_ent;
  logic                    key_clr;
  logic [4*NUM_DIGITS-1:0] entry;
  logic [3:0]              count;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    valid;
  logic                    err;

  modport master (
    output keypad, key_ent, key_clr,
    input  entry, count, value, valid, err
  );

  modport slave (
    input  keypad, key_ent, key_clr,
    output entry, count, value, valid, err
  );
endinterface

// File: rtl/keypad_digit_entry.sv
// BCD digit entry buffer: ports clk, rst (async active-low), bus (slave).
// Optional inactivity auto-commit enabled by macro KEYPAD_TIMEOUT_EN.
module keypad_digit_entry #(
  parameter int NUM_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  keypad_digit_entry_if.slave bus
);
  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   entry_q;
  logic [W-1:0]   value_q;
  logic [3:0]     count_q;
  logic           valid_q;
  logic           err_q;

  logic [3:0]     dig;
  logic           one_hot;
  logic           multi;
  logic           full;
  logic           accept;
  logic           reject;
  logic           commit;
  logic           to_hit;
  logic [W-1:0]   shifted;
  logic [W-1:0]   nxt_entry;

  always_comb begin
    dig = '0;
    for (int i = 0; i < 10; i++)
      if (bus.keypad[i]) dig = 4'(i);
    one_hot   = $countones(bus.keypad) == 1;
    multi     = $countones(bus.keypad) > 1;
    full      = count_q == 4'(NUM_DIGITS);
    accept    = one_hot && !full;
    reject    = multi || (one_hot && full);
    shifted   = entry_q << 4;
    shifted[3:0] = dig;
    nxt_entry = accept ? shifted : entry_q;
    // a digit accepted this cycle also arms a commit from IDLE/DONE;
    // an accepted digit restarts the inactivity window instead
    commit    = (state == ENTRY || accept) &&
                (bus.key_ent || (to_hit && !accept));
  end

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= '0;
    end else if (bus.key_clr || accept || commit ||
                 state != ENTRY) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign to_hit = (state == ENTRY) &&
                  (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  // no inactivity counter: never fires for a legal TIMEOUT_CYCLES
  assign to_hit = (TIMEOUT_CYCLES < 2);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      entry_q <= '0;
      value_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (bus.key_clr) begin
        entry_q <= '0;
        count_q <= '0;
        state   <= IDLE;
      end else if (commit) begin
        value_q <= nxt_entry;
        entry_q <= '0;
        count_q <= '0;
        valid_q <= 1'b1;
        state   <= DONE;
      end else begin
        entry_q <= nxt_entry;
        count_q <= count_q + {3'b000, accept};
        err_q   <= reject;
        state   <= (count_q != 4'd0 || accept) ? ENTRY : IDLE;
      end
    end
  end

  assign bus.entry = entry_q;
  assign bus.count = count_q;
  assign bus.value = value_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_keypad_digit_entry.sv
// Testbench for keypad_digit_entry: vector table plus
// reset-mid-entry and inactivity timeout sequences.
module tb_keypad_digit_entry;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  keypad_digit_entry_if #(.NUM_DIGITS(4)) bus ();

  keypad_digit_entry #(
    .NUM_DIGITS(4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  kp;
    logic        ent;
    logic        clr;
    logic [15:0] e_entry;
    logic [3:0]  e_cnt;
    logic        e_valid;
    logic        e_err;
    logic [15:0] e_value;
  } vec_t;

  vec_t vt[$];

  function automatic logic [9:0] k(input int n);
    logic [9:0] one;
    one = 10'd1;
    return one << n;
  endfunction

  function automatic vec_t mk(
    input logic [9:0] kp, input logic ent, input logic clr,
    input logic [15:0] en, input logic [3:0] c,
    input logic v, input logic e, input logic [15:0] val);
    vec_t r;
    r.kp = kp; r.ent = ent; r.clr = clr;
    r.e_entry = en; r.e_cnt = c;
    r.e_valid = v; r.e_err = e; r.e_value = val;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] kp, input logic ent,
                       input logic clr);
    @(negedge clk);
    bus.keypad  = kp;
    bus.key_ent = ent;
    bus.key_clr = clr;
    @(posedge clk);
    #1;
    bus.keypad  = '0;
    bus.key_ent = 1'b0;
    bus.key_clr = 1'b0;
  endtask

  task automatic check_all(input string nm, input vec_t v);
    chk({nm, "_entry"}, 32'(bus.entry), 32'(v.e_entry));
    chk({nm, "_count"}, 32'(bus.count), 32'(v.e_cnt));
    chk({nm, "_valid"}, 32'(bus.valid), 32'(v.e_valid));
    chk({nm, "_err"},   32'(bus.err),   32'(v.e_err));
    chk({nm, "_value"}, 32'(bus.value), 32'(v.e_value));
  endtask

  initial begin
    int   n;
    int   nv;
    logic got;
    checks = 0;
    errors = 0;
    bus.keypad  = '0;
    bus.key_ent = 1'b0;
    bus.key_clr = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;

    vt.push_back(mk(k(1), 0, 0, 16'h0001, 1, 0, 0, 16'h0000));
    vt.push_back(mk(k(2), 0, 0, 16'h0012, 2, 0, 0, 16'h0000));
    vt.push_back(mk(k(3), 0, 0, 16'h0123, 3, 0, 0, 16'h0000));
    vt.push_back(mk('0,   1, 0, 16'h0000, 0, 1, 0, 16'h0123));
    vt.push_back(mk('0,   0, 0, 16'h0000, 0, 0, 0, 16'h0123));
    vt.push_back(mk(k(9), 0, 0, 16'h0009, 1, 0, 0, 16'h0123));
    vt.push_back(mk(k(8), 0, 0, 16'h0098, 2, 0, 0, 16'h0123));
    vt.push_back(mk(k(7), 0, 0, 16'h0987, 3, 0, 0, 16'h0123));
    vt.push_back(mk(k(6), 0, 0, 16'h9876, 4, 0, 0, 16'h0123));
    vt.push_back(mk(k(5), 0, 0, 16'h9876, 4, 0, 1, 16'h0123));
    vt.push_back(mk('0,   0, 0, 16'h9876, 4, 0, 0, 16'h0123));
    vt.push_back(mk('0,   1, 0, 16'h0000, 0, 1, 0, 16'h9876));
    vt.push_back(mk(10'h006, 0, 0, 16'h0000, 0, 0, 1, 16'h9876));
    vt.push_back(mk(k(4), 0, 0, 16'h0004, 1, 0, 0, 16'h9876));
    vt.push_back(mk(10'h006, 0, 0, 16'h0004, 1, 0, 1, 16'h9876));
    vt.push_back(mk('0,   1, 1, 16'h0000, 0, 0, 0, 16'h9876));
    vt.push_back(mk('0,   1, 0, 16'h0000, 0, 0, 0, 16'h9876));
    vt.push_back(mk(k(3), 1, 0, 16'h0000, 0, 1, 0, 16'h0003));
    vt.push_back(mk(k(5), 0, 0, 16'h0005, 1, 0, 0, 16'h0003));
    vt.push_back(mk(k(6), 0, 0, 16'h0056, 2, 0, 0, 16'h0003));
    vt.push_back(mk(k(7), 0, 1, 16'h0000, 0, 0, 0, 16'h0003));
    vt.push_back(mk(k(1), 0, 0, 16'h0001, 1, 0, 0, 16'h0003));
    vt.push_back(mk(k(2), 0, 0, 16'h0012, 2, 0, 0, 16'h0003));
    vt.push_back(mk(k(3), 0, 0, 16'h0123, 3, 0, 0, 16'h0003));
    vt.push_back(mk(k(4), 0, 0, 16'h1234, 4, 0, 0, 16'h0003));
    vt.push_back(mk(k(5), 1, 0, 16'h0000, 0, 1, 0, 16'h1234));
    vt.push_back(mk(k(8), 0, 0, 16'h0008, 1, 0, 0, 16'h1234));
    vt.push_back(mk(10'h003, 1, 0, 16'h0000, 0, 1, 0, 16'h0008));
    vt.push_back(mk(10'h3FF, 0, 0, 16'h0000, 0, 0, 1, 16'h0008));
    vt.push_back(mk('0,   0, 0, 16'h0000, 0, 0, 0, 16'h0008));
    vt.push_back(mk(k(0), 0, 0, 16'h0000, 1, 0, 0, 16'h0008));
    vt.push_back(mk(k(9), 0, 0, 16'h0009, 2, 0, 0, 16'h0008));
    vt.push_back(mk('0,   1, 0, 16'h0000, 0, 1, 0, 16'h0009));

    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all("reset", mk('0, 0, 0, 16'h0, 0, 0, 0, 16'h0));

    foreach (vt[i]) begin
      drive(vt[i].kp, vt[i].ent, vt[i].clr);
      check_all($sformatf("v%0d", i), vt[i]);
    end

    drive(k(4), 0, 0);
    drive(k(2), 0, 0);
    chk("pre_rst_entry", 32'(bus.entry), 32'h0042);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_all("async_rst", mk('0, 0, 0, 16'h0, 0, 0, 0, 16'h0));
    @(negedge clk);
    rst = 1'b1;
    nv = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.valid) nv++;
    end
    chk("rst_release_valid", 32'(nv), 32'd0);
    chk("rst_release_count", 32'(bus.count), 32'd0);
    drive(k(7), 0, 0);
    check_all("post_rst_d7", mk('0, 0, 0, 16'h0007, 1, 0, 0, 16'h0));
    drive('0, 1, 0);
    check_all("post_rst_ent", mk('0, 0, 0, 16'h0, 0, 1, 0, 16'h0007));

    drive(k(5), 0, 0);
    chk("to_digit_count", 32'(bus.count), 32'd1);
`ifdef KEYPAD_TIMEOUT_EN
    n = 0;
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid) begin
        got = 1'b1;
        n = i;
      end
    end
    chk("timeout_seen", 32'(got), 32'd1);
    chk("timeout_cycles", 32'(n), 32'd20);
    chk("timeout_value", 32'(bus.value), 32'h0005);
    chk("timeout_count", 32'(bus.count), 32'd0);
`else
    nv = 0;
    got = 1'b0;
    repeat (1000) begin
      @(posedge clk);
      #1;
      if (bus.valid) nv++;
    end
    chk("no_timeout_valid", 32'(nv), 32'd0);
    chk("no_timeout_count", 32'(bus.count), 32'd1);
    chk("no_timeout_entry", 32'(bus.entry), 32'h0005);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
